// File: rtl/reg_file_2r1w.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : reg_file_2r1w
//  Purpose  : General-purpose register file with 2**ADDR_WIDTH entries of
//             DATA_WIDTH bits. It has one synchronous write port and two
//             combinational read ports (rs / rt). Entry 0 is hardwired to
//             zero. An optional write-to-read bypass is selected by BYPASS.
//  Ports    : clk          - rising-edge clock
//             areset       - asynchronous reset, active-low
//             write_enable - commit wdata to waddr on the rising edge
//             waddr, wdata - write address / data
//             raddr_a      - read port A address (rs)
//             rdata_a      - read port A data
//             raddr_b      - read port B address (rt)
//             rdata_b      - read port B data
//  Revision : 1.0 - initial release
// ============================================================================
module reg_file_2r1w #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int BYPASS     = 1
) (
    input  logic                  clk,
    input  logic                  areset,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr_a,
    input  logic [ADDR_WIDTH-1:0] raddr_b,
    output logic [DATA_WIDTH-1:0] rdata_a,
    output logic [DATA_WIDTH-1:0] rdata_b
);

    localparam int c_DEPTH = 2 ** ADDR_WIDTH;

    // Read view of every entry; element 0 is a constant zero, the rest are
    // driven by the per-entry flops below.
    logic [DATA_WIDTH-1:0] w_entry [0:c_DEPTH-1];
    logic                  w_hit_a;
    logic                  w_hit_b;

    assign w_entry[0] = '0;

    genvar i;
    generate
        for (i = 1; i < c_DEPTH; i++) begin : g_entry
            logic [DATA_WIDTH-1:0] r_q;
            logic                  w_sel;

            assign w_sel = write_enable && (waddr == ADDR_WIDTH'(i));

            always_ff @(posedge clk or negedge areset) begin
                if (!areset) begin
                    r_q <= '0;
                end else if (w_sel) begin
                    r_q <= wdata;
                end
            end

            assign w_entry[i] = r_q;
        end
    endgenerate

    // Forwarding of an in-flight write to a read port. Address 0 is excluded
    // so the zero register can never observe write data.
    generate
        if (BYPASS != 0) begin : g_bypass
            assign w_hit_a = write_enable && (waddr != '0) && (raddr_a == waddr);
            assign w_hit_b = write_enable && (waddr != '0) && (raddr_b == waddr);
        end else begin : g_no_bypass
            assign w_hit_a = 1'b0;
            assign w_hit_b = 1'b0;
        end
    endgenerate

    // Outputs are forced to zero while reset is held so that a bypassed
    // write cannot leak through during reset.
    assign rdata_a = !areset ? '0 : (w_hit_a ? wdata : w_entry[raddr_a]);
    assign rdata_b = !areset ? '0 : (w_hit_b ? wdata : w_entry[raddr_b]);

endmodule
`default_nettype wire

// File: tb/tb_reg_file_2r1w.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_reg_file_2r1w
//  Purpose  : Self-checking bench for reg_file_2r1w. Two instances share all
//             inputs, one with bypass enabled and one without, and both are
//             compared against a simple array model of the register file.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file_2r1w;

    logic        clk;
    logic        areset;
    logic        write_enable;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr_a;
    logic [4:0]  raddr_b;
    logic [31:0] w_rdata_a_byp;
    logic [31:0] w_rdata_b_byp;
    logic [31:0] w_rdata_a_nob;
    logic [31:0] w_rdata_b_nob;

    int n_checks;
    int n_fail;

    // Architectural state of the register file as the bench understands it.
    logic [31:0] model [0:31];

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] ea_byp;
        logic [31:0] eb_byp;
        logic [31:0] ea_nob;
        logic [31:0] eb_nob;
    } vec_t;

    vec_t tbl [12];

    reg_file_2r1w #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1)) dut_byp (
        .clk          (clk),
        .areset       (areset),
        .write_enable (write_enable),
        .waddr        (waddr),
        .wdata        (wdata),
        .raddr_a      (raddr_a),
        .raddr_b      (raddr_b),
        .rdata_a      (w_rdata_a_byp),
        .rdata_b      (w_rdata_b_byp)
    );

    reg_file_2r1w #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(0)) dut_nob (
        .clk          (clk),
        .areset       (areset),
        .write_enable (write_enable),
        .waddr        (waddr),
        .wdata        (wdata),
        .raddr_a      (raddr_a),
        .raddr_b      (raddr_b),
        .rdata_a      (w_rdata_a_nob),
        .rdata_b      (w_rdata_b_nob)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Expected read value from the register-file rules.
    function automatic logic [31:0] exp_read(input logic [4:0] addr, input bit byp);
        if (!areset)                                          return 32'h0;
        if (addr == 5'd0)                                     return 32'h0;
        if (byp && write_enable && waddr != 5'd0 && addr == waddr) return wdata;
        return model[addr];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] ea1, input logic [31:0] eb1,
                           input logic [31:0] ea0, input logic [31:0] eb0);
        chk({tag, " a_byp"}, w_rdata_a_byp, ea1);
        chk({tag, " b_byp"}, w_rdata_b_byp, eb1);
        chk({tag, " a_nob"}, w_rdata_a_nob, ea0);
        chk({tag, " b_nob"}, w_rdata_b_nob, eb0);
    endtask

    task automatic chk_model(input string tag);
        chk_all(tag, exp_read(raddr_a, 1'b1), exp_read(raddr_b, 1'b1),
                     exp_read(raddr_a, 1'b0), exp_read(raddr_b, 1'b0));
    endtask

    task automatic clear_model();
        for (int k = 0; k < 32; k++) model[k] = 32'h0;
    endtask

    // Advance through one rising edge, committing the write to the model,
    // and return 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        if (areset && write_enable && waddr != 5'd0) model[waddr] = wdata;
        #1;
    endtask

    task automatic set_in(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                          input logic [4:0] ra, input logic [4:0] rb);
        write_enable = we;
        waddr        = wa;
        wdata        = wd;
        raddr_a      = ra;
        raddr_b      = rb;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        clear_model();
        areset = 1'b0;
        set_in(1'b1, 5'd5, 32'hFFFF_0000, 5'd5, 5'd0);

        // Reset state: outputs zero even with a bypass-eligible write pending.
        #2;
        chk_all("reset_idle", 32'h0, 32'h0, 32'h0, 32'h0);
        step();
        chk_all("reset_write_ignored", 32'h0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        areset = 1'b1;
        set_in(1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
        #1;
        chk_all("reset_release", 32'h0, 32'h0, 32'h0, 32'h0);

        // Reset clears the file asynchronously.
        step();
        set_in(1'b1, 5'd5, 32'hDAAB4620, 5'd0, 5'd0);
        step();
        set_in(1'b1, 5'd6, 32'h12345678, 5'd0, 5'd0);
        step();
        set_in(1'b0, 5'd0, 32'h0, 5'd5, 5'd6);
        #1;
        chk_all("t1_written", 32'hDAAB4620, 32'h12345678, 32'hDAAB4620, 32'h12345678);
        @(negedge clk);
        #1 areset = 1'b0;
        clear_model();
        #1;
        chk_all("t1_async_clear", 32'h0, 32'h0, 32'h0, 32'h0);
        set_in(1'b1, 5'd5, 32'h0BAD_0BAD, 5'd5, 5'd6);
        step();
        chk_all("t1_write_in_reset", 32'h0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        set_in(1'b0, 5'd0, 32'h0, 5'd5, 5'd6);
        areset = 1'b1;
        #1;
        chk_all("t1_after_release", 32'h0, 32'h0, 32'h0, 32'h0);
        step();

        // Directed vectors; expectations are checked before each edge.
        tbl[0]  = '{1'b1, 5'd1,  32'h246B780F, 5'd1, 5'd31, 32'h246B780F, 32'h0,        32'h0,        32'h0};
        tbl[1]  = '{1'b1, 5'd31, 32'h87654321, 5'd1, 5'd31, 32'h246B780F, 32'h87654321, 32'h246B780F, 32'h0};
        tbl[2]  = '{1'b0, 5'd31, 32'hFFFFFFFF, 5'd1, 5'd31, 32'h246B780F, 32'h87654321, 32'h246B780F, 32'h87654321};
        tbl[3]  = '{1'b0, 5'd0,  32'hFFFFFFFF, 5'd1, 5'd31, 32'h246B780F, 32'h87654321, 32'h246B780F, 32'h87654321};
        tbl[4]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0, 5'd0,  32'h0,        32'h0,        32'h0,        32'h0};
        tbl[5]  = '{1'b0, 5'd0,  32'h0,        5'd0, 5'd0,  32'h0,        32'h0,        32'h0,        32'h0};
        tbl[6]  = '{1'b1, 5'd7,  32'h00000011, 5'd7, 5'd1,  32'h00000011, 32'h246B780F, 32'h0,        32'h246B780F};
        tbl[7]  = '{1'b1, 5'd7,  32'h00000022, 5'd7, 5'd31, 32'h00000022, 32'h87654321, 32'h00000011, 32'h87654321};
        tbl[8]  = '{1'b0, 5'd7,  32'h0,        5'd7, 5'd7,  32'h00000022, 32'h00000022, 32'h00000022, 32'h00000022};
        tbl[9]  = '{1'b1, 5'd9,  32'hCAFEF00D, 5'd9, 5'd9,  32'hCAFEF00D, 32'hCAFEF00D, 32'h0,        32'h0};
        tbl[10] = '{1'b0, 5'd0,  32'h0,        5'd9, 5'd9,  32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D};
        tbl[11] = '{1'b0, 5'd0,  32'h0,        5'd9, 5'd10, 32'hCAFEF00D, 32'h0,        32'hCAFEF00D, 32'h0};
        for (int v = 0; v < 12; v++) begin
            set_in(tbl[v].we, tbl[v].wa, tbl[v].wd, tbl[v].ra, tbl[v].rb);
            #1;
            chk_all($sformatf("vec%0d", v), tbl[v].ea_byp, tbl[v].eb_byp, tbl[v].ea_nob, tbl[v].eb_nob);
            step();
        end

        // Reset pulse mid-operation, then a write right after release.
        set_in(1'b1, 5'd3, 32'hA5A5A5A5, 5'd3, 5'd0);
        step();
        set_in(1'b0, 5'd0, 32'h0, 5'd3, 5'd9);
        #1;
        chk_all("t6_r3_written", 32'hA5A5A5A5, 32'hCAFEF00D, 32'hA5A5A5A5, 32'hCAFEF00D);
        areset = 1'b0;
        #3;
        areset = 1'b1;
        clear_model();
        set_in(1'b1, 5'd4, 32'h5A5A5A5A, 5'd0, 5'd0);
        step();
        write_enable = 1'b0;
        for (int k = 0; k < 32; k++) begin
            logic [31:0] ea;
            logic [31:0] eb;
            raddr_a = 5'(k);
            raddr_b = 5'(31 - k);
            ea = (k == 4)      ? 32'h5A5A5A5A : 32'h0;
            eb = (31 - k == 4) ? 32'h5A5A5A5A : 32'h0;
            #1;
            chk_all($sformatf("t6_scan%0d", k), ea, eb, ea, eb);
        end
        step();

        // Randomized traffic against the model, with occasional reset pulses.
        for (int c = 0; c < 400; c++) begin
            logic [4:0] wa;
            wa = 5'($urandom_range(0, 31));
            set_in(1'($urandom_range(0, 1)), wa, $urandom,
                   ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31)),
                   ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31)));
            #1;
            chk_model($sformatf("rand%0d", c));
            if ($urandom_range(0, 39) == 0) begin
                #1 areset = 1'b0;
                #1;
                chk_model($sformatf("rand%0d_rst", c));
                clear_model();
                #1 areset = 1'b1;
                #1;
                chk_model($sformatf("rand%0d_post_rst", c));
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
- 32-entry by 32-bit general-purpose register file for the single-cycle processor datapath.
- It is the read side of the architectural register interface: it holds values written back by the datapath and serves them to two operand read ports (rs, rt).
- Built from the same storage semantics as the single `register` cell: clocked write with write enable, and asynchronous clear.
- Entry 0 is hardwired to zero.

Parameters:
- DATA_WIDTH, 32, width of each entry and of all data ports.
- ADDR_WIDTH, 5, address width; depth is 2**ADDR_WIDTH.
- BYPASS, 1, when 1 a same-cycle write is forwarded to any read port addressing the written entry; when 0 reads return the stored value only.

Ports:
- clk  input  1  rising-edge clock.
- areset  input  1  asynchronous reset, active-low (keeps the codebase name `areset`; asserted when 0).
- write_enable  input  1  commit wdata to waddr on the rising clk edge.
- waddr  input  ADDR_WIDTH  write address.
- wdata  input  DATA_WIDTH  write data.
- raddr_a  input  ADDR_WIDTH  read port A address (rs).
- raddr_b  input  ADDR_WIDTH  read port B address (rt).
- rdata_a  output  DATA_WIDTH  read port A data.
- rdata_b  output  DATA_WIDTH  read port B data.

Behaviour:
- Storage: entries 1..31 are flops.
  - Entry 0 has no storage and always reads 0.
  - A write to address 0 is silently discarded.
- Reset:
  - areset = 0 clears entries 1..31 to 0 immediately, independent of clk.
  - While areset is held low, writes are ignored and both rdata outputs read 0.
  - Release is synchronous-safe: the first write that can land is at the first rising edge with areset = 1.
- Write:
  - On the rising clk edge with areset = 1, write_enable = 1 and waddr != 0: entry[waddr] <= wdata.
  - Zero-cycle latency to the stored value: the entry reflects the new data after that edge.
  - write_enable = 0 leaves all entries unchanged.
- Read:
  - Combinational.
  - rdata_x = 0 if raddr_x == 0; otherwise entry[raddr_x].
- Bypass (BYPASS = 1):
  - Applies when write_enable = 1, waddr != 0 and raddr_x == waddr in the same cycle.
  - rdata_x = wdata combinationally, before the edge.
  - The bypass is never applied for address 0.
- Both ports may address the same entry at once; both return identical data.
- Simultaneous reset and write: reset wins and the entry stays 0.
- Reset asserted mid-cycle after a write: all entries clear at once, and outputs go to 0 within the same cycle.
- Address range is full 0..31; no out-of-range case exists.
- No X propagation: every entry has a defined reset value.

Test Plan:
1. Reset clears the file.
   - Stimulus: write 32'hDAAB4620 to r5 and 32'h12345678 to r6; then drive areset = 0 asynchronously between edges.
   - Required response: rdata_a (r5) and rdata_b (r6) both read 0 before the next edge.
   - Stimulus: hold reset and attempt a write to r5.
   - Required response: r5 stays 0.
2. Basic write/read.
   - Stimulus: write 32'h246B780F to r1 and 32'h87654321 to r31 on consecutive edges; then set raddr_a = 1, raddr_b = 31.
   - Required response: rdata_a = 246B780F, rdata_b = 87654321.
   - Stimulus: one further edge with write_enable = 0 and wdata = FFFFFFFF.
   - Required response: both values unchanged.
3. Zero register.
   - Stimulus: write 32'hFFFFFFFF to r0 with raddr_a = raddr_b = 0.
   - Required response: both outputs read 0 before and after the edge, including with BYPASS = 1.
4. Bypass.
   - Stimulus: with r7 = 32'h00000011, drive write_enable = 1, waddr = 7, wdata = 32'h00000022, raddr_a = 7.
   - Required response with BYPASS = 1: rdata_a = 22 before the edge.
   - Required response with BYPASS = 0: rdata_a = 11 before the edge and 22 after it.
5. Dual-port same address and port independence.
   - Stimulus: raddr_a = raddr_b = 9 with r9 = 32'hCAFEF00D.
   - Required response: both outputs read CAFEF00D.
   - Stimulus: change raddr_b to 10 (r10 = 0).
   - Required response: rdata_b = 0 and rdata_a is unaffected.
6. Reset mid-operation.
   - Stimulus: write r3 = 32'hA5A5A5A5, then pulse areset low for 3 ns between edges, then release and write r4 = 32'h5A5A5A5A on the next edge.
   - Required response: r3 reads 0, r4 reads 5A5A5A5A, and all other entries read 0.
